fib_sequencer: RTL and testbench

- Parametrised control sequencer that drives the CR16 datapath to compute a Fibonacci-style sequence into registers r0..r(N-1).
- Seeds and sequence length are run-time inputs; a start/busy/done handshake, abort, and sticky overflow detection are provided.
- Sits between a top-level shell (switches, LEDs, 7-seg) and the datapath; replaces hard-wired demo FSMs.
- All control outputs are registered (Moore); no latches.

---
 rtl/fib_sequencer_pkg.sv | 29 ++
 rtl/one_hot_decoder.sv | 25 ++
 rtl/fib_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_fib_sequencer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fib_sequencer_pkg
// Shared definitions for the Fibonacci control sequencer:
//   - state_t      : sequencer FSM states
//   - OPCODE_ADD   : ALU opcode used for every datapath write
//   - FLAG_*       : bit positions within the datapath status flag vector
// -----------------------------------------------------------------------------
package fib_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SEED0 = 3'd2,
        SEED1 = 3'd3,
        STEP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [3:0] OPCODE_ADD = 4'd1;

    // CR16 status flag layout: carry, low, flag (signed overflow), zero, negative.
    localparam int FLAG_CARRY        = 0;
    localparam int FLAG_LOW          = 1;
    localparam int FLAG_OVF          = 2;
    localparam int FLAG_ZERO         = 3;
    localparam int FLAG_NEG          = 4;
    localparam int STATUS_FLAG_COUNT = 5;

endpackage

// File: rtl/one_hot_decoder.sv
// -----------------------------------------------------------------------------
// one_hot_decoder
// Binary select to one-hot vector with a global enable. With enable low the
// output is all zeros, so the result is always one-hot or zero.
// Ports:
//   sel     in  SEL_WIDTH  binary index
//   enable  in  1          gates every output bit
//   one_hot out OUT_WIDTH  decoded vector
// -----------------------------------------------------------------------------
module one_hot_decoder #(
    parameter int SEL_WIDTH = 4,
    parameter int OUT_WIDTH = 16
) (
    input  logic [SEL_WIDTH-1:0] sel,
    input  logic                 enable,
    output logic [OUT_WIDTH-1:0] one_hot
);

    always_comb begin
        for (int i = 0; i < OUT_WIDTH; i++) begin
            one_hot[i] = enable && (sel == SEL_WIDTH'(i));
        end
    end

endmodule

// File: rtl/fib_sequencer.sv
// -----------------------------------------------------------------------------
// fib_sequencer
// Control sequencer that drives the CR16 datapath to fill r0..r(len-1) with a
// Fibonacci-style sequence: r0 = seed_a, r1 = seed_b, r[i] = r[i-2] + r[i-1].
// Sequence: IDLE -> CLEAR -> SEED0 -> SEED1 -> STEP* -> DONE -> IDLE.
// Every control output is registered (Moore).
// Ports:
//   I_CLK, I_NRESET       clock, asynchronous active-low reset
//   I_START, I_ABORT      run request (IDLE only), abort (beats start)
//   I_SEED_A, I_SEED_B    values for r0 and r1
//   I_LENGTH              registers to fill, clamped to 2..REG_COUNT
//   I_RESULT_BUS          datapath result for the current controls
//   I_STATUS_FLAGS        datapath flags, carry at CARRY_FLAG_BIT
//   O_DATAPATH_NRESET     datapath register clear, active-low
//   O_REG_WRITE_ENABLE    one-hot register write enable
//   O_REG_A/B_SELECT      read port selects
//   O_IMMEDIATE(_SELECT)  immediate value and B-operand mux control
//   O_OPCODE              ALU opcode
//   O_BUSY, O_DONE        run in progress, one-cycle completion pulse
//   O_OVERFLOW            sticky carry seen during the current run
//   O_LAST_VALUE          value written to the final register
// -----------------------------------------------------------------------------
module fib_sequencer
    import fib_sequencer_pkg::*;
#(
    parameter int REG_COUNT      = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int SEL_WIDTH      = $clog2(REG_COUNT),
    parameter int CARRY_FLAG_BIT = FLAG_CARRY
) (
    input  logic                         I_CLK,
    input  logic                         I_NRESET,
    input  logic                         I_START,
    input  logic                         I_ABORT,
    input  logic [DATA_WIDTH-1:0]        I_SEED_A,
    input  logic [DATA_WIDTH-1:0]        I_SEED_B,
    input  logic [SEL_WIDTH:0]           I_LENGTH,
    input  logic [DATA_WIDTH-1:0]        I_RESULT_BUS,
    input  logic [STATUS_FLAG_COUNT-1:0] I_STATUS_FLAGS,
    output logic                         O_DATAPATH_NRESET,
    output logic [REG_COUNT-1:0]         O_REG_WRITE_ENABLE,
    output logic [SEL_WIDTH-1:0]         O_REG_A_SELECT,
    output logic [SEL_WIDTH-1:0]         O_REG_B_SELECT,
    output logic [DATA_WIDTH-1:0]        O_IMMEDIATE,
    output logic                         O_IMMEDIATE_SELECT,
    output logic [3:0]                   O_OPCODE,
    output logic                         O_BUSY,
    output logic                         O_DONE,
    output logic                         O_OVERFLOW,
    output logic [DATA_WIDTH-1:0]        O_LAST_VALUE
);

    localparam logic [SEL_WIDTH:0]   LEN_ONE = (SEL_WIDTH+1)'(1);
    localparam logic [SEL_WIDTH:0]   LEN_MIN = (SEL_WIDTH+1)'(2);
    localparam logic [SEL_WIDTH:0]   LEN_MAX = (SEL_WIDTH+1)'(REG_COUNT);
    localparam logic [SEL_WIDTH-1:0] IDX_ONE = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] IDX_TWO = SEL_WIDTH'(2);

    // Run state
    state_t                state_q, state_d;
    logic [SEL_WIDTH-1:0]  idx_q, idx_d;
    logic [SEL_WIDTH:0]    len_q, len_d;
    logic [DATA_WIDTH-1:0] seed_a_q, seed_a_d;
    logic [DATA_WIDTH-1:0] seed_b_q, seed_b_d;
    logic                  overflow_d;
    logic [DATA_WIDTH-1:0] last_value_d;
    logic [SEL_WIDTH:0]    len_clamped;
    logic                  carry;
    logic                  last_step;

    // Next-cycle control values, registered straight onto the outputs
    logic                  datapath_nreset_d;
    logic                  write_en_d;
    logic [SEL_WIDTH-1:0]  write_sel_d;
    logic [REG_COUNT-1:0]  write_enable_d;
    logic [SEL_WIDTH-1:0]  a_sel_d;
    logic [SEL_WIDTH-1:0]  b_sel_d;
    logic [DATA_WIDTH-1:0] imm_d;
    logic                  imm_sel_d;
    logic [3:0]            opcode_d;
    logic                  busy_d;
    logic                  done_d;

    // Only the carry bit steers the sequencer; the remaining flags are
    // collected here so they are visibly intentional.
    logic unused_flags;
    assign unused_flags = ^I_STATUS_FLAGS;

    assign carry     = I_STATUS_FLAGS[CARRY_FLAG_BIT];
    assign last_step = ({1'b0, idx_q} == (len_q - LEN_ONE));

    always_comb begin
        if (I_LENGTH < LEN_MIN) begin
            len_clamped = LEN_MIN;
        end else if (I_LENGTH > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end else begin
            len_clamped = I_LENGTH;
        end
    end

    // NOTE: every variable assigned in this block gets a default first, so
    // no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        seed_a_d     = seed_a_q;
        seed_b_d     = seed_b_q;
        overflow_d   = O_OVERFLOW;
        last_value_d = O_LAST_VALUE;

        if (I_ABORT) begin
            // Abort freezes overflow/last value; in IDLE it also masks start.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (I_START) begin
                        len_d      = len_clamped;
                        seed_a_d   = I_SEED_A;
                        seed_b_d   = I_SEED_B;
                        overflow_d = 1'b0;
                        state_d    = CLEAR;
                    end
                end
                CLEAR: state_d = SEED0;
                SEED0: state_d = SEED1;
                SEED1: begin
                    if (len_q == LEN_MIN) begin
                        last_value_d = I_RESULT_BUS;
                        state_d      = DONE;
                    end else begin
                        idx_d   = IDX_TWO;
                        state_d = STEP;
                    end
                end
                STEP: begin
                    if (carry) begin
                        overflow_d = 1'b1;
                    end
                    if (last_step) begin
                        last_value_d = I_RESULT_BUS;
                        state_d      = DONE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Controls are decoded from the state being entered, so the registered
    // outputs line up with the state they belong to.
    always_comb begin
        datapath_nreset_d = 1'b1;
        write_en_d        = 1'b0;
        write_sel_d       = '0;
        a_sel_d           = '0;
        b_sel_d           = '0;
        imm_d             = '0;
        imm_sel_d         = 1'b0;
        opcode_d          = 4'd0;
        busy_d            = 1'b0;
        done_d            = 1'b0;

        case (state_d)
            CLEAR: begin
                datapath_nreset_d = 1'b0;
                busy_d            = 1'b1;
            end
            SEED0: begin
                // r0 was just cleared, so r0 + imm writes seed_a.
                write_en_d  = 1'b1;
                write_sel_d = '0;
                a_sel_d     = '0;
                imm_d       = seed_a_q;
                imm_sel_d   = 1'b1;
                opcode_d    = OPCODE_ADD;
                busy_d      = 1'b1;
            end
            SEED1: begin
                write_en_d  = 1'b1;
                write_sel_d = IDX_ONE;
                a_sel_d     = IDX_ONE;
                imm_d       = seed_b_q;
                imm_sel_d   = 1'b1;
                opcode_d    = OPCODE_ADD;
                busy_d      = 1'b1;
            end
            STEP: begin
                write_en_d  = 1'b1;
                write_sel_d = idx_d;
                a_sel_d     = idx_d - IDX_TWO;
                b_sel_d     = idx_d - IDX_ONE;
                opcode_d    = OPCODE_ADD;
                busy_d      = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    one_hot_decoder #(
        .SEL_WIDTH (SEL_WIDTH),
        .OUT_WIDTH (REG_COUNT)
    ) u_write_decoder (
        .sel     (write_sel_d),
        .enable  (write_en_d),
        .one_hot (write_enable_d)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q            <= IDLE;
            idx_q              <= '0;
            len_q              <= '0;
            seed_a_q           <= '0;
            seed_b_q           <= '0;
            O_DATAPATH_NRESET  <= 1'b1;
            O_REG_WRITE_ENABLE <= '0;
            O_REG_A_SELECT     <= '0;
            O_REG_B_SELECT     <= '0;
            O_IMMEDIATE        <= '0;
            O_IMMEDIATE_SELECT <= 1'b0;
            O_OPCODE           <= 4'd0;
            O_BUSY             <= 1'b0;
            O_DONE             <= 1'b0;
            O_OVERFLOW         <= 1'b0;
            O_LAST_VALUE       <= '0;
        end else begin
            state_q            <= state_d;
            idx_q              <= idx_d;
            len_q              <= len_d;
            seed_a_q           <= seed_a_d;
            seed_b_q           <= seed_b_d;
            O_DATAPATH_NRESET  <= datapath_nreset_d;
            O_REG_WRITE_ENABLE <= write_enable_d;
            O_REG_A_SELECT     <= a_sel_d;
            O_REG_B_SELECT     <= b_sel_d;
            O_IMMEDIATE        <= imm_d;
            O_IMMEDIATE_SELECT <= imm_sel_d;
            O_OPCODE           <= opcode_d;
            O_BUSY             <= busy_d;
            O_DONE             <= done_d;
            O_OVERFLOW         <= overflow_d;
            O_LAST_VALUE       <= last_value_d;
        end
    end

endmodule

// File: tb/tb_fib_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fib_sequencer
// Bench for fib_sequencer with a behavioural CR16 datapath (register file plus
// adder). Each run pushes its expected outcome onto a scoreboard when started;
// the entry is popped and compared when O_DONE appears.
// -----------------------------------------------------------------------------
module tb_fib_sequencer;

    localparam int RC = 16;
    localparam int DW = 16;
    localparam int SW = 4;

    typedef struct {
        logic [DW-1:0]         last;
        logic                  ovf;
        int                    len;
        logic [RC-1:0][DW-1:0] regs;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [DW-1:0] seed_a;
    logic [DW-1:0] seed_b;
    logic [SW:0]   length;
    logic [DW-1:0] result;
    logic [4:0]    flags;
    logic          dp_nreset;
    logic [RC-1:0] we;
    logic [SW-1:0] a_sel;
    logic [SW-1:0] b_sel;
    logic [DW-1:0] imm;
    logic          imm_sel;
    logic [3:0]    opcode;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [DW-1:0] last_value;

    logic [DW-1:0] dp_regs [RC];
    logic [DW:0]   sum;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    int   trace_q[$];
    logic [DW-1:0] last_expected = '0;

    fib_sequencer dut (
        .I_CLK              (clk),
        .I_NRESET           (rst_n),
        .I_START            (start),
        .I_ABORT            (abort),
        .I_SEED_A           (seed_a),
        .I_SEED_B           (seed_b),
        .I_LENGTH           (length),
        .I_RESULT_BUS       (result),
        .I_STATUS_FLAGS     (flags),
        .O_DATAPATH_NRESET  (dp_nreset),
        .O_REG_WRITE_ENABLE (we),
        .O_REG_A_SELECT     (a_sel),
        .O_REG_B_SELECT     (b_sel),
        .O_IMMEDIATE        (imm),
        .O_IMMEDIATE_SELECT (imm_sel),
        .O_OPCODE           (opcode),
        .O_BUSY             (busy),
        .O_DONE             (done),
        .O_OVERFLOW         (overflow),
        .O_LAST_VALUE       (last_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: adder only for opcode ADD, carry on flag bit 0, zero on bit 3.
    always_comb begin
        sum    = {1'b0, dp_regs[a_sel]} + {1'b0, (imm_sel ? imm : dp_regs[b_sel])};
        result = (opcode == 4'd1) ? sum[DW-1:0] : '0;
        flags  = {1'b0, (result == '0), 2'b00, (opcode == 4'd1) && sum[DW]};
    end

    initial begin
        for (int i = 0; i < RC; i++) dp_regs[i] = '0;
    end

    always @(posedge clk) begin
        if (!dp_nreset) begin
            for (int i = 0; i < RC; i++) dp_regs[i] <= '0;
        end else begin
            for (int i = 0; i < RC; i++) if (we[i]) dp_regs[i] <= result;
        end
    end

    function automatic int onehot_index(logic [RC-1:0] v);
        for (int i = 0; i < RC; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Write-enable monitor: never multi-hot, and logs the written register order.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones(we) > 1) begin
                failures++;
                $display("FAIL onehot_we got=%h want=one-hot-or-zero", we);
            end
            if (we != '0) trace_q.push_back(onehot_index(we));
        end
    end

    function automatic exp_t make_expect(logic [DW-1:0] sa, logic [DW-1:0] sb, logic [SW:0] ln);
        exp_t        e;
        logic [DW:0] s;
        int          n;
        n      = (ln < 2) ? 2 : ((ln > RC) ? RC : int'(ln));
        e.regs = '0;
        e.ovf  = 1'b0;
        e.len  = n;
        e.regs[0] = sa;
        e.regs[1] = sb;
        for (int i = 2; i < n; i++) begin
            s         = {1'b0, e.regs[i-2]} + {1'b0, e.regs[i-1]};
            e.regs[i] = s[DW-1:0];
            if (s[DW]) e.ovf = 1'b1;
        end
        e.last = e.regs[n-1];
        return e;
    endfunction

    // Called on a negedge in IDLE; the following posedge samples the start.
    task automatic start_run(input logic [DW-1:0] sa, input logic [DW-1:0] sb, input logic [SW:0] ln);
        seed_a = sa;
        seed_b = sb;
        length = ln;
        trace_q.delete();
        sb_q.push_back(make_expect(sa, sb, ln));
        start = 1'b1;
    endtask

    // n counts negedges after the start was driven: n=1 is CLEAR, so DONE
    // is expected at n = len + 2.
    task automatic wait_done(input int n0, input int budget, input bit drop_start,
                             output int n, output bit seen);
        n    = n0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (drop_start && n == 1) start = 1'b0;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic scoreboard_compare(input string tag, input int n, input bit seen);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s_scoreboard got=empty want=entry", tag);
            return;
        end
        e = sb_q.pop_front();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout got=no_done want=done_at_%0d", tag, e.len + 2);
        end else begin
            checks++;
            if (n != e.len + 2) begin
                failures++;
                $display("FAIL %s_latency got=%0d want=%0d", tag, n, e.len + 2);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL %s_busy_at_done got=%b want=0", tag, busy);
            end
            checks++;
            if (last_value !== e.last) begin
                failures++;
                $display("FAIL %s_last_value got=%h want=%h", tag, last_value, e.last);
            end
            checks++;
            if (overflow !== e.ovf) begin
                failures++;
                $display("FAIL %s_overflow got=%b want=%b", tag, overflow, e.ovf);
            end
            checks++;
            if (trace_q.size() != e.len) begin
                failures++;
                $display("FAIL %s_write_count got=%0d want=%0d", tag, trace_q.size(), e.len);
            end else begin
                for (int k = 0; k < e.len; k++) begin
                    checks++;
                    if (trace_q[k] != k) begin
                        failures++;
                        $display("FAIL %s_write_order[%0d] got=r%0d want=r%0d", tag, k, trace_q[k], k);
                    end
                end
            end
            for (int i = 0; i < RC; i++) begin
                checks++;
                if (dp_regs[i] !== e.regs[i]) begin
                    failures++;
                    $display("FAIL %s_r%0d got=%h want=%h", tag, i, dp_regs[i], e.regs[i]);
                end
            end
            last_expected = e.last;
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL %s_done_pulse got=%b want=0", tag, done);
            end
        end
        trace_q.delete();
    endtask

    task automatic test_reset();
        logic [64:0] obs;
        start  = 1'b0;
        abort  = 1'b0;
        seed_a = '0;
        seed_b = '0;
        length = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        obs = {dp_nreset, we, a_sel, b_sel, imm, imm_sel, opcode, busy, done, overflow, last_value};
        checks++;
        if (obs !== {1'b1, 64'b0}) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=%h", obs, {1'b1, 64'b0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || we !== '0) begin
            failures++;
            $display("FAIL reset_idle got=busy%b_we%h want=busy0_we0000", busy, we);
        end
    endtask

    task automatic test_fib_basic();
        int n; bit seen;
        start_run(16'd1, 16'd1, 5'd8);
        wait_done(0, 60, 1'b1, n, seen);
        scoreboard_compare("basic", n, seen);
    endtask

    task automatic test_wrap();
        int n; bit seen;
        start_run(16'h4000, 16'h6000, 5'd5);
        wait_done(0, 60, 1'b1, n, seen);
        scoreboard_compare("wrap", n, seen);
    endtask

    task automatic test_clamp();
        int n; bit seen;
        logic [SW:0] lens [3];
        lens = '{5'd0, 5'd1, 5'd20};
        for (int t = 0; t < 3; t++) begin
            start_run(16'd1, 16'd1, lens[t]);
            wait_done(0, 60, 1'b1, n, seen);
            scoreboard_compare($sformatf("clamp_len%0d", lens[t]), n, seen);
        end
    endtask

    task automatic test_abort();
        int n; bit seen; bit done_seen;
        logic [DW-1:0] want_regs [RC];
        start_run(16'd1, 16'd1, 5'd8);
        void'(sb_q.pop_back());
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || we !== 16'h0010) begin
            failures++;
            $display("FAIL abort_third_step got=busy%b_we%h want=busy1_we0010", busy, we);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || we !== '0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_to_idle got=busy%b_we%h_done%b want=busy0_we0000_done0", busy, we, done);
        end
        done_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            failures++;
            $display("FAIL abort_no_done got=activity want=none");
        end
        checks++;
        if (last_value !== last_expected || overflow !== 1'b0) begin
            failures++;
            $display("FAIL abort_kept got=last%h_ovf%b want=last%h_ovf0", last_value, overflow, last_expected);
        end
        want_regs = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd0, 16'd0, 16'd0,
                      16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        for (int i = 0; i < RC; i++) begin
            checks++;
            if (dp_regs[i] !== want_regs[i]) begin
                failures++;
                $display("FAIL abort_r%0d got=%h want=%h", i, dp_regs[i], want_regs[i]);
            end
        end
        // Abort together with start in IDLE keeps the sequencer idle.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_beats_start got=busy%b want=busy0", busy);
        end
        @(negedge clk);
        start_run(16'd2, 16'd3, 5'd5);
        wait_done(0, 60, 1'b1, n, seen);
        scoreboard_compare("after_abort", n, seen);
    endtask

    task automatic test_start_ignored();
        int n; bit seen;
        start_run(16'd3, 16'd4, 5'd6);
        @(negedge clk);
        start  = 1'b0;
        seed_a = 16'd100;
        seed_b = 16'd200;
        length = 5'd3;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, 60, 1'b0, n, seen);
        scoreboard_compare("start_ignored", n, seen);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored_no_rerun got=busy%b want=busy0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int n; bit seen;
        start_run(16'h4000, 16'h6000, 5'd5);
        @(negedge clk);
        // Seeds are latched at the start edge; these apply to the second run.
        seed_a = 16'd1;
        seed_b = 16'd1;
        length = 5'd4;
        sb_q.push_back(make_expect(16'd1, 16'd1, 5'd4));
        wait_done(1, 60, 1'b0, n, seen);
        scoreboard_compare("b2b_run1", n, seen);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle_gap got=busy%b want=busy0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart got=busy%b_ovf%b want=busy1_ovf0", busy, overflow);
        end
        wait_done(1, 60, 1'b0, n, seen);
        scoreboard_compare("b2b_run2", n, seen);
    endtask

    task automatic test_async_reset();
        int n; bit seen; bit active;
        logic [64:0] obs;
        start_run(16'd1, 16'd1, 5'd8);
        void'(sb_q.pop_back());
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        obs = {dp_nreset, we, a_sel, b_sel, imm, imm_sel, opcode, busy, done, overflow, last_value};
        checks++;
        if (obs !== {1'b1, 64'b0}) begin
            failures++;
            $display("FAIL async_reset_outputs got=%h want=%h", obs, {1'b1, 64'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        active = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy !== 1'b0 || we !== '0 || done !== 1'b0) active = 1'b1;
        end
        checks++;
        if (active) begin
            failures++;
            $display("FAIL async_reset_quiet got=activity want=none");
        end
        start_run(16'd5, 16'd7, 5'd7);
        wait_done(0, 60, 1'b1, n, seen);
        scoreboard_compare("after_reset", n, seen);
    endtask

    initial begin
        rst_n = 1'b1;
        test_reset();
        test_fib_basic();
        test_wrap();
        test_clamp();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drained got=%0d want=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
